// File: rtl/rx_valid_framer.sv
// rx_valid_framer: word-level framer for a source-synchronous RX link whose
// valid lane carries an 8-UI marker pattern co-timed with the data lanes.
// It searches for the bit offset (0..7) that frames the valid lane, locks
// after LOCK_CNT consecutive framed words at the same offset, then emits
// aligned data words with a byte-group valid mask through a 2-entry FIFO.
//
// Ports:
//   clk          RX word clock, rising edge
//   reset        synchronous, active-high
//   in_valid     new deserialized word on rxval_word / rxdata_word
//   rxval_word   valid-lane word, bit 0 earliest UI
//   rxdata_word  data-lane words, lane k at [k*WORD_W +: WORD_W]
//   out_valid    FIFO non-empty, out_data / out_mask hold a framed word
//   out_ready    consumer accepts when out_valid is also high
//   out_data     aligned data, same lane packing as rxdata_word
//   out_mask     bit g high: byte group g of every lane valid
//   locked       framer is in LOCKED
//   align_off    bit offset in use
//   lock_lost    one-cycle pulse on LOCKED-to-SEARCH
//   overflow     sticky, a framed word was dropped on a full FIFO
module rx_valid_framer #(
  parameter int         LANES     = 4,
  parameter int         WORD_W    = 32,
  parameter logic [7:0] VALID_PAT = 8'hF0,
  parameter int         LOCK_CNT  = 4,
  parameter int         ERR_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [WORD_W-1:0]         rxval_word,
  input  logic [LANES*WORD_W-1:0]   rxdata_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WORD_W-1:0]   out_data,
  output logic [WORD_W/8-1:0]       out_mask,
  output logic                      locked,
  output logic [2:0]                align_off,
  output logic                      lock_lost,
  output logic                      overflow
);

  localparam int GROUPS = WORD_W / 8;
  localparam int MW     = $clog2(LOCK_CNT + 1);
  localparam int EW     = $clog2(ERR_LIMIT + 1);
  localparam int DW     = LANES * WORD_W;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] prev_val_q;
  logic [DW-1:0]     prev_data_q;
  logic [MW-1:0]     match_q, match_d, match_inc;
  logic [2:0]        cand_q, cand_d;
  logic [2:0]        off_q, off_d;
  logic [EW-1:0]     err_q, err_d, err_inc;
  logic              lost_q, lost_d;

  // Aligned word: last r bits of prv followed by the first WORD_W-r of cur.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] cur,
                                                    input logic [WORD_W-1:0] prv,
                                                    input logic [2:0]        r);
    logic [2*WORD_W-1:0] cat;
    int unsigned         sh;
    sh  = WORD_W - int'(r);
    cat = {cur, prv} >> sh;
    return cat[WORD_W-1:0];
  endfunction

  function automatic logic [GROUPS-1:0] pat_mask(input logic [WORD_W-1:0] w);
    logic [GROUPS-1:0] m;
    m = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      m[g] = (w[8*g +: 8] == VALID_PAT);
    end
    return m;
  endfunction

  function automatic logic is_good(input logic [WORD_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (w[8*g +: 8] != VALID_PAT && w[8*g +: 8] != 8'h00) ok = 1'b0;
    end
    return ok;
  endfunction

  // Search: smallest offset producing a framed valid-lane word.
  logic              found;
  logic [2:0]        hit_r;
  logic [WORD_W-1:0] cand_word;

  always_comb begin
    found     = 1'b0;
    hit_r     = '0;
    cand_word = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      cand_word = align_word(rxval_word, prev_val_q, 3'(r));
      if (!found && is_good(cand_word) && (|pat_mask(cand_word))) begin
        found = 1'b1;
        hit_r = 3'(r);
      end
    end
  end

  // Locked evaluation at the committed offset.
  logic [WORD_W-1:0] lk_val;
  logic [GROUPS-1:0] lk_mask;
  logic              lk_good;
  logic [DW-1:0]     lk_data;

  always_comb begin
    lk_val  = align_word(rxval_word, prev_val_q, off_q);
    lk_mask = pat_mask(lk_val);
    lk_good = is_good(lk_val);
    lk_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lk_data[k*WORD_W +: WORD_W] = align_word(rxdata_word[k*WORD_W +: WORD_W],
                                               prev_data_q[k*WORD_W +: WORD_W], off_q);
    end
  end

  logic push;

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    cand_d    = cand_q;
    off_d     = off_q;
    err_d     = err_q;
    lost_d    = 1'b0;
    push      = 1'b0;
    match_inc = match_q + 1'b1;
    err_inc   = err_q + 1'b1;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (found) begin
            cand_d  = hit_r;
            match_d = (hit_r == cand_q) ? match_inc : MW'(1);
            if (match_d == MW'(LOCK_CNT)) begin
              state_d = LOCKED;
              off_d   = hit_r;
              err_d   = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (lk_good) begin
            push  = |lk_mask;
            err_d = '0;
          end else if (err_inc == EW'(ERR_LIMIT)) begin
            state_d = SEARCH;
            lost_d  = 1'b1;
            match_d = '0;
            err_d   = '0;
          end else begin
            err_d = err_inc;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEARCH;
      prev_val_q  <= '0;
      prev_data_q <= '0;
      match_q     <= '0;
      cand_q      <= '0;
      off_q       <= '0;
      err_q       <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      cand_q  <= cand_d;
      off_q   <= off_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
      if (in_valid) begin
        prev_val_q  <= rxval_word;
        prev_data_q <= rxdata_word;
      end
    end
  end

  // 2-entry output FIFO; a push into a full FIFO is accepted only when the
  // head is popped in the same cycle.
  logic [DW-1:0]     fifo_data [2];
  logic [GROUPS-1:0] fifo_mask [2];
  logic              wr_q, rd_q;
  logic [1:0]        cnt_q;
  logic              pop, full, accept;
  logic              ovf_q;

  assign pop    = (cnt_q != 2'd0) && out_ready;
  assign full   = (cnt_q == 2'd2);
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_mask[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        fifo_data[wr_q] <= lk_data;
        fifo_mask[wr_q] <= lk_mask;
        wr_q            <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_data[rd_q] : '0;
  assign out_mask  = out_valid ? fifo_mask[rd_q] : '0;
  assign locked    = (state_q == LOCKED);
  assign align_off = off_q;
  assign lock_lost = lost_q;
  assign overflow  = ovf_q;

endmodule
